pipo_rr_arbiter: RTL and testbench
==================================

// Module: pipo_rr_arbiter
// PURPOSE
// - Shares one WIDTH-bit parallel-in/parallel-out holding register between NREQ requesters.
// - Owns that register: an enable-gated bank of async-reset D flops.
// - Round-robin arbitration picks which requester's word is captured; a valid/ready
//   handshake drains the word to a single consumer.
// - Sits between several producers and one downstream consumer as a 1-entry shared buffer.
// PARAMETERS
// - NREQ   4  number of requesters (2..8)
// - WIDTH  4  data width of the shared register
// - IDW    2  width of out_src; must equal clog2(NREQ)
// PORTS
// - clk        in   1           rising-edge clock
// - reset      in   1           asynchronous, active-high reset
// - req        in   NREQ        req[i]=1: requester i has a word on req_data slice i
// - req_data   in   NREQ*WIDTH  slice i = req_data[i*WIDTH +: WIDTH]
// - gnt        out  NREQ        one-hot grant, combinational; word i captured at this edge
// - out_valid  out  1           shared register holds an undelivered word
// - out_ready  in   1           consumer accepts out_data this cycle
// - out_data   out  WIDTH       shared register contents
// - out_src    out  IDW         index of the requester whose word is in out_data
// BEHAVIOUR
// - Reset (async, immediate): out_valid=0, out_data=0, out_src=0, rr pointer=0.
//   gnt=0 while reset is high.
// - State (out_valid): EMPTY(0) / FULL(1).
//   - EMPTY: grant if any req -> FULL. No req -> stay EMPTY.
//   - FULL & out_ready & winner -> FULL, new word loaded (back-to-back).
//   - FULL & out_ready & no req -> EMPTY.
//   - FULL & !out_ready -> FULL, all registers hold, gnt=0.
// - can_load = !out_valid | out_ready.
//   gnt = can_load ? onehot(winner) : 0, with gnt=0 if req==0.
// - Winner: first i with req[i]=1, scanning ptr, ptr+1, ... wrapping modulo NREQ.
// - On a grant edge:
//   - out_data <= slice(winner)
//   - out_src <= winner
//   - out_valid <= 1
//   - ptr <= (winner+1) mod NREQ; wraps NREQ-1 -> 0
// - ptr only changes on a grant edge.
// - Latency: req to out_valid is 1 cycle when EMPTY. Throughput: 1 word/cycle while out_ready=1.
// - Requester handshake:
//   - hold req[i] and data stable until gnt[i] is seen high;
//   - deasserting req before grant is legal (withdraw, no capture);
//   - a requester granted with req still high next cycle is a new word.
// - gnt is never asserted for i with req[i]=0. At most one gnt bit is high.
// - Fairness: a continuously requesting i is granted within NREQ grants.
// - out_data, out_src stable while out_valid & !out_ready. No data change without a grant.
// - Reset mid-operation: a held word is dropped (out_valid=0, no delivery).
//   Arbitration restarts at index 0.
// TESTING
// - Reset with req=4'b1111 -> gnt=0, out_valid=0, out_data=0. After release, first gnt=4'b0001.
// - req=4'b1111, out_ready=1 constant, data i=4'hA+i, 8 cycles:
//   - gnt sequence 1,2,4,8,1,2,4,8;
//   - out_data A,B,C,D,A,B,C,D;
//   - out_src 0,1,2,3,0,...
// - req=4'b0100 only, data 4'h5, out_ready=0:
//   - one grant; out_valid=1, out_data=5, out_src=2;
//   - gnt=0 for 5 cycles of backpressure, out_data held;
//   - out_ready=1 -> delivered, and a second grant issues in the same cycle.
// - Wrap: ptr=3 (last grant to 2), req=4'b0001 -> gnt=4'b0001. Next ptr=1.
// - Withdraw: req[1] high 2 cycles while FULL & !out_ready, then dropped.
//   -> gnt[1] never asserted, out_src never 1.
// - Assert reset while FULL with out_data=4'h9 -> out_valid=0, out_data=0 immediately.
//   Word never observed on the consumer side.

Source files
------------

// File: rtl/pipo_rr_arbiter.sv
// One shared WIDTH-bit holding register fed by NREQ requesters under round-robin
// arbitration and drained to a single consumer through a valid/ready handshake.
module pipo_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_src
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   src_q, src_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             found;
  logic [IDW-1:0]   winner;
  int               scan_idx;
  logic             can_load;
  logic             load;

  // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = IDW'(scan_idx);
      end
    end
  end

  // A new word may enter when the register is empty or is being drained this cycle.
  assign can_load = (state_q == EMPTY) || out_ready;
  assign load     = found && can_load && !reset;

  always_comb begin
    gnt     = '0;
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (load) begin
      gnt[winner] = 1'b1;
      state_d     = FULL;
      data_d      = req_data[winner*WIDTH +: WIDTH];
      src_d       = winner;
      ptr_d       = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Directed bench for pipo_rr_arbiter: stimulus queues expected deliveries,
// a negedge monitor pops and compares whenever the consumer takes a word.
module tb_pipo_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IDW-1:0]   src;
  } exp_t;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_src;

  logic [WIDTH-1:0] dat [NREQ];
  exp_t             exp_q[$];
  int               n_cmp;
  int               n_fail;

  pipo_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_src  (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = dat[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every word the consumer accepts must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_delivery: got data=%0h src=%0d, expected no word", out_data, out_src);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("deliver_data", 32'(out_data), 32'(e.data));
        check("deliver_src", 32'(out_src), 32'(e.src));
      end
    end
  end

  // Called at posedge+1: drive inputs, check the combinational grant mid-cycle,
  // queue the word expected to be captured, and return at the next posedge+1.
  task automatic step(input logic [NREQ-1:0] r, input logic rdy, input logic [NREQ-1:0] exp_g);
    exp_t e;
    req       = r;
    out_ready = rdy;
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(exp_g));
    for (int i = 0; i < NREQ; i++) begin
      if (exp_g[i]) begin
        e.data = dat[i];
        e.src  = IDW'(i);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input logic v, input logic [WIDTH-1:0] d, input logic [IDW-1:0] s);
    check("out_valid", 32'(out_valid), 32'(v));
    check("out_data", 32'(out_data), 32'(d));
    check("out_src", 32'(out_src), 32'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) dat[i] = WIDTH'(4'hA + i);

    // Reset holds everything idle even with all requests high and a clock edge.
    @(posedge clk);
    #1;
    check("reset_gnt", 32'(gnt), 32'h0);
    check_out(1'b0, 4'h0, 2'd0);
    reset = 1'b0;

    // Full contention, consumer always ready: strict rotation.
    step(4'b1111, 1'b1, 4'b0001);
    step(4'b1111, 1'b1, 4'b0010);
    step(4'b1111, 1'b1, 4'b0100);
    step(4'b1111, 1'b1, 4'b1000);
    step(4'b1111, 1'b1, 4'b0001);
    step(4'b1111, 1'b1, 4'b0010);
    step(4'b1111, 1'b1, 4'b0100);
    step(4'b1111, 1'b1, 4'b1000);
    step(4'b0000, 1'b1, 4'b0000);
    check("drained_valid", 32'(out_valid), 32'h0);

    // Single requester under backpressure.
    dat[2] = 4'h5;
    step(4'b0100, 1'b0, 4'b0100);
    check_out(1'b1, 4'h5, 2'd2);
    for (int c = 0; c < 5; c++) begin
      step(4'b0100, 1'b0, 4'b0000);
      check_out(1'b1, 4'h5, 2'd2);
    end
    // Release: delivery and a fresh grant in the same cycle.
    step(4'b0100, 1'b1, 4'b0100);
    check_out(1'b1, 4'h5, 2'd2);

    // Pointer wrap: last grant was to 2, so ptr=3 and only req[0] is set.
    step(4'b0001, 1'b1, 4'b0001);
    // ptr is now 1, so requester 3 beats requester 0.
    step(4'b1001, 1'b1, 4'b1000);

    // Withdraw while full and stalled: requester 1 must never be granted.
    step(4'b0010, 1'b0, 4'b0000);
    step(4'b0010, 1'b0, 4'b0000);
    check_out(1'b1, 4'hD, 2'd3);
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    check("withdraw_empty", 32'(out_valid), 32'h0);

    // Reset while a word is held: the word is dropped immediately.
    dat[1] = 4'h9;
    step(4'b0010, 1'b0, 4'b0010);
    check_out(1'b1, 4'h9, 2'd1);
    #2;
    out_ready = 1'b1;
    reset     = 1'b1;
    exp_q.delete();
    #1;
    check_out(1'b0, 4'h0, 2'd0);
    check("reset_mid_gnt", 32'(gnt), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(4'b0000, 1'b1, 4'b0000);
    check("post_reset_valid", 32'(out_valid), 32'h0);
    // Pointer restarted at 0: requester 1 wins over 2.
    step(4'b0110, 1'b1, 4'b0010);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
